// File: rtl/lpif_link_sync_pkg.sv
// Shared definitions for the LPIF slave link synchronizer.
// Contents:
//   tx_state_t       - TX FSM encoding (2 bits): TX_OFF, TX_DLY, TX_ON
//   rx_state_t       - RX FSM encoding (3 bits): RX_OFF, RX_HUNT, RX_DLY, RX_ON, RX_BACKOFF
//   STB_LOCK_DEFAULT - default number of consecutive strobes needed to lock
package lpif_link_sync_pkg;

   typedef enum logic [1:0] {
      TX_OFF = 2'd0,
      TX_DLY = 2'd1,
      TX_ON  = 2'd2
   } tx_state_t;

   typedef enum logic [2:0] {
      RX_OFF     = 3'd0,
      RX_HUNT    = 3'd1,
      RX_DLY     = 3'd2,
      RX_ON      = 3'd3,
      RX_BACKOFF = 3'd4
   } rx_state_t;

   localparam int unsigned STB_LOCK_DEFAULT = 4;

endpackage

// File: rtl/lpif_sync_dly_cnt.sv
// 16-bit delay counter: load, decrement-to-zero, zero detect.
// Ports:
//   clk        in   clock, rising edge
//   rst_n      in   asynchronous active-low reset (count -> 0)
//   load       in   load load_value (has priority over dec)
//   load_value in   16-bit value sampled only when load=1
//   dec        in   decrement request; ignored at zero so the count never wraps
//   zero       out  count == 0
module lpif_sync_dly_cnt (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        load,
   input  logic [15:0] load_value,
   input  logic        dec,
   output logic        zero
);

   logic [15:0] count;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count <= 16'd0;
      end else if (load) begin
         count <= load_value;
      end else if (dec && (count != 16'd0)) begin
         count <= count - 16'd1;
      end
   end

   assign zero = (count == 16'd0);

endmodule

// File: rtl/lpif_slave_link_sync.sv
// LPIF slave-end link synchronizer.
// Delays TX online by delay_y cycles, emits a persistent strobe/marker once TX
// is up, hunts for STB_LOCK consecutive received strobes, waits delay_x cycles
// before qualifying the RX datapath, and backs off delay_z cycles after a
// strobe loss (recording a sticky error and a saturating error count).
// Ports:
//   clk_wr, rst_wr_n         clock, async active-low reset
//   tx_online, rx_online     local PHY online indications
//   rx_stb_userbit           strobe bit of each received word
//   delay_x/y/z_value        RX post-lock delay, TX online delay, RX backoff
//   tx_online_delay          delayed TX online (registered)
//   rx_online_delay          RX datapath qualified (registered)
//   tx_auto_stb_userbit      persistent strobe (registered)
//   tx_auto_mrk_userbit      persistent marker (registered)
//   sync_locked              RX in RX_DLY or RX_ON (registered)
//   sync_error               sticky strobe-loss flag
//   debug_status             state / counter snapshot
module lpif_slave_link_sync
   import lpif_link_sync_pkg::*;
#(
   parameter int unsigned STB_LOCK     = STB_LOCK_DEFAULT,
   parameter int unsigned MARKER_WIDTH = 2
) (
   input  logic                    clk_wr,
   input  logic                    rst_wr_n,
   input  logic                    tx_online,
   input  logic                    rx_online,
   input  logic                    rx_stb_userbit,
   input  logic [15:0]             delay_x_value,
   input  logic [15:0]             delay_y_value,
   input  logic [15:0]             delay_z_value,
   output logic                    tx_online_delay,
   output logic                    rx_online_delay,
   output logic                    tx_auto_stb_userbit,
   output logic [MARKER_WIDTH-1:0] tx_auto_mrk_userbit,
   output logic                    sync_locked,
   output logic                    sync_error,
   output logic [31:0]             debug_status
);

   localparam logic [3:0] HUNT_LAST = 4'(STB_LOCK - 1);

   tx_state_t   tx_state, tx_nxt;
   rx_state_t   rx_state, rx_nxt;
   logic [3:0]  hunt_cnt, hunt_nxt;
   logic [7:0]  err_cnt;
   logic        tx_zero, rx_zero;
   logic        tx_load, tx_dec;
   logic        rx_load, rx_dec;
   logic [15:0] rx_load_value;
   logic        rx_go, hunt_lock, stb_loss;

   // RX may only run while TX is up and stays up on this edge; sampling
   // tx_online here lets a TX drop take RX down on the same edge as TX.
   assign rx_go     = rx_online & tx_online_delay & tx_online;
   assign hunt_lock = (rx_state == RX_HUNT) & rx_go & rx_stb_userbit & (hunt_cnt == HUNT_LAST);
   assign stb_loss  = (rx_state == RX_ON) & rx_go & ~rx_stb_userbit;

   assign tx_load = (tx_state == TX_OFF) & tx_online;
   assign tx_dec  = (tx_state == TX_DLY) & tx_online & ~tx_zero;

   assign rx_load       = hunt_lock | stb_loss;
   assign rx_load_value = hunt_lock ? delay_x_value : delay_z_value;
   assign rx_dec        = rx_go & ~rx_zero &
                          (((rx_state == RX_DLY) & rx_stb_userbit) | (rx_state == RX_BACKOFF));

   lpif_sync_dly_cnt u_tx_cnt (
      .clk        (clk_wr),
      .rst_n      (rst_wr_n),
      .load       (tx_load),
      .load_value (delay_y_value),
      .dec        (tx_dec),
      .zero       (tx_zero)
   );

   lpif_sync_dly_cnt u_rx_cnt (
      .clk        (clk_wr),
      .rst_n      (rst_wr_n),
      .load       (rx_load),
      .load_value (rx_load_value),
      .dec        (rx_dec),
      .zero       (rx_zero)
   );

   always_comb begin
      tx_nxt = tx_state;
      if (!tx_online) begin
         tx_nxt = TX_OFF;
      end else begin
         case (tx_state)
            TX_OFF:  tx_nxt = TX_DLY;
            TX_DLY:  if (tx_zero) tx_nxt = TX_ON;
            TX_ON:   tx_nxt = TX_ON;
            default: tx_nxt = TX_OFF;
         endcase
      end
   end

   // hunt_cnt is only non-zero inside RX_HUNT, so every entry to RX_HUNT
   // starts a fresh strobe run.
   always_comb begin
      rx_nxt   = rx_state;
      hunt_nxt = hunt_cnt;
      if (!rx_go) begin
         rx_nxt   = RX_OFF;
         hunt_nxt = 4'd0;
      end else begin
         case (rx_state)
            RX_OFF: begin
               rx_nxt   = RX_HUNT;
               hunt_nxt = 4'd0;
            end
            RX_HUNT: begin
               if (!rx_stb_userbit) begin
                  hunt_nxt = 4'd0;
               end else if (hunt_cnt == HUNT_LAST) begin
                  rx_nxt   = RX_DLY;
                  hunt_nxt = 4'd0;
               end else begin
                  hunt_nxt = hunt_cnt + 4'd1;
               end
            end
            RX_DLY: begin
               if (!rx_stb_userbit) rx_nxt = RX_HUNT;
               else if (rx_zero)    rx_nxt = RX_ON;
            end
            RX_ON:      if (!rx_stb_userbit) rx_nxt = RX_BACKOFF;
            RX_BACKOFF: if (rx_zero) rx_nxt = RX_HUNT;
            default: begin
               rx_nxt   = RX_OFF;
               hunt_nxt = 4'd0;
            end
         endcase
      end
   end

   // Outputs are registered from the next state so they line up with the
   // state register rather than trailing it by a cycle.
   always_ff @(posedge clk_wr or negedge rst_wr_n) begin
      if (!rst_wr_n) begin
         tx_state            <= TX_OFF;
         rx_state            <= RX_OFF;
         hunt_cnt            <= 4'd0;
         err_cnt             <= 8'd0;
         tx_online_delay     <= 1'b0;
         tx_auto_stb_userbit <= 1'b0;
         tx_auto_mrk_userbit <= '0;
         rx_online_delay     <= 1'b0;
         sync_locked         <= 1'b0;
         sync_error          <= 1'b0;
      end else begin
         tx_state            <= tx_nxt;
         rx_state            <= rx_nxt;
         hunt_cnt            <= hunt_nxt;
         tx_online_delay     <= (tx_nxt == TX_ON);
         tx_auto_stb_userbit <= (tx_nxt == TX_ON);
         tx_auto_mrk_userbit <= {MARKER_WIDTH{tx_nxt == TX_ON}};
         rx_online_delay     <= (rx_nxt == RX_ON);
         sync_locked         <= (rx_nxt == RX_DLY) || (rx_nxt == RX_ON);
         if (stb_loss) begin
            sync_error <= 1'b1;
            if (err_cnt != 8'hFF) err_cnt <= err_cnt + 8'd1;
         end
      end
   end

   assign debug_status = {rx_state, tx_state, sync_error, hunt_cnt,
                          tx_online_delay, rx_online_delay, 4'b0000,
                          err_cnt, 8'h00};

endmodule

// File: tb/tb_lpif_slave_link_sync.sv
// Self-checking bench for lpif_slave_link_sync: directed scenarios with
// literal expectations plus randomized traffic compared every cycle against a
// behavioural model built from run lengths and elapsed-cycle counts.
module tb_lpif_slave_link_sync;
   import lpif_link_sync_pkg::*;

   localparam int STB_LOCK = 4;
   localparam int MW       = 2;

   // ---------------- clock / reset / DUT ----------------
   logic          clk_wr = 1'b0;
   logic          rst_wr_n = 1'b0;
   logic          tx_online = 1'b0;
   logic          rx_online = 1'b0;
   logic          rx_stb_userbit = 1'b0;
   logic [15:0]   delay_x_value = 16'd0;
   logic [15:0]   delay_y_value = 16'd0;
   logic [15:0]   delay_z_value = 16'd0;
   logic          tx_online_delay, rx_online_delay, tx_auto_stb_userbit;
   logic [MW-1:0] tx_auto_mrk_userbit;
   logic          sync_locked, sync_error;
   logic [31:0]   debug_status;

   always #5 clk_wr = ~clk_wr;

   lpif_slave_link_sync #(.STB_LOCK(STB_LOCK), .MARKER_WIDTH(MW)) dut (
      .clk_wr              (clk_wr),
      .rst_wr_n            (rst_wr_n),
      .tx_online           (tx_online),
      .rx_online           (rx_online),
      .rx_stb_userbit      (rx_stb_userbit),
      .delay_x_value       (delay_x_value),
      .delay_y_value       (delay_y_value),
      .delay_z_value       (delay_z_value),
      .tx_online_delay     (tx_online_delay),
      .rx_online_delay     (rx_online_delay),
      .tx_auto_stb_userbit (tx_auto_stb_userbit),
      .tx_auto_mrk_userbit (tx_auto_mrk_userbit),
      .sync_locked         (sync_locked),
      .sync_error          (sync_error),
      .debug_status        (debug_status)
   );

   // ---------------- scoreboard counters ----------------
   int n_checks = 0;
   int n_fail   = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- behavioural model ----------------
   // TX: up once tx_online has been high for delay_y+2 consecutive edges.
   // RX: idle / searching for a strobe run / settling / up / waiting after loss.
   typedef enum int {M_IDLE, M_SEARCH, M_SETTLE, M_UP, M_WAIT} mode_t;

   mode_t m_mode    = M_IDLE;
   int    m_streak  = 0;
   int    m_elapsed = 0;
   int    m_target  = 0;
   int    m_errcnt  = 0;
   bit    m_err     = 1'b0;
   int    m_tx_run  = 0;
   int    m_tx_y    = 0;
   bit    m_tx_on   = 1'b0;

   always @(posedge clk_wr or negedge rst_wr_n) begin : model
      mode_t n_mode;
      int    n_streak, n_elapsed, n_target, n_errcnt, n_run, n_y;
      bit    n_err, go;
      if (!rst_wr_n) begin
         m_mode <= M_IDLE; m_streak <= 0; m_elapsed <= 0; m_target <= 0;
         m_errcnt <= 0; m_err <= 1'b0; m_tx_run <= 0; m_tx_y <= 0; m_tx_on <= 1'b0;
      end else begin
         n_mode = m_mode; n_streak = m_streak; n_elapsed = m_elapsed;
         n_target = m_target; n_errcnt = m_errcnt; n_err = m_err;
         n_run = m_tx_run; n_y = m_tx_y;
         go = rx_online && tx_online && m_tx_on;
         if (!go) begin
            n_mode = M_IDLE; n_streak = 0;
         end else begin
            case (m_mode)
               M_IDLE: begin n_mode = M_SEARCH; n_streak = 0; end
               M_SEARCH: begin
                  if (rx_stb_userbit) begin
                     n_streak = m_streak + 1;
                     if (n_streak == STB_LOCK) begin
                        n_mode = M_SETTLE; n_streak = 0;
                        n_elapsed = 0; n_target = int'(delay_x_value);
                     end
                  end else begin
                     n_streak = 0;
                  end
               end
               M_SETTLE: begin
                  if (!rx_stb_userbit)          n_mode = M_SEARCH;
                  else if (m_elapsed == m_target) n_mode = M_UP;
                  else                          n_elapsed = m_elapsed + 1;
               end
               M_UP: begin
                  if (!rx_stb_userbit) begin
                     n_mode = M_WAIT; n_elapsed = 0; n_target = int'(delay_z_value);
                     n_err = 1'b1;
                     if (m_errcnt < 255) n_errcnt = m_errcnt + 1;
                  end
               end
               M_WAIT: begin
                  if (m_elapsed == m_target) n_mode = M_SEARCH;
                  else                       n_elapsed = m_elapsed + 1;
               end
            endcase
         end
         if (tx_online) begin
            n_run = m_tx_run + 1;
            if (n_run == 1) n_y = int'(delay_y_value);
         end else begin
            n_run = 0;
         end
         m_mode <= n_mode; m_streak <= n_streak; m_elapsed <= n_elapsed;
         m_target <= n_target; m_errcnt <= n_errcnt; m_err <= n_err;
         m_tx_run <= n_run; m_tx_y <= n_y;
         m_tx_on <= (n_run >= n_y + 2);
      end
   end

   // ---------------- every-cycle compare ----------------
   always @(negedge clk_wr) begin : cmp
      logic [2:0]  rx_enc;
      logic [1:0]  tx_enc;
      logic [31:0] exp_dbg;
      case (m_mode)
         M_IDLE:   rx_enc = RX_OFF;
         M_SEARCH: rx_enc = RX_HUNT;
         M_SETTLE: rx_enc = RX_DLY;
         M_UP:     rx_enc = RX_ON;
         default:  rx_enc = RX_BACKOFF;
      endcase
      tx_enc  = (m_tx_run == 0) ? TX_OFF : (m_tx_on ? TX_ON : TX_DLY);
      exp_dbg = {rx_enc, tx_enc, m_err, m_streak[3:0], m_tx_on, (m_mode == M_UP),
                 4'b0000, m_errcnt[7:0], 8'h00};
      check("m_tx_online_delay", 32'(tx_online_delay),     32'(m_tx_on));
      check("m_tx_auto_stb",     32'(tx_auto_stb_userbit), 32'(m_tx_on));
      check("m_tx_auto_mrk",     32'(tx_auto_mrk_userbit), m_tx_on ? 32'd3 : 32'd0);
      check("m_rx_online_delay", 32'(rx_online_delay),     32'(m_mode == M_UP));
      check("m_sync_locked",     32'(sync_locked),         32'((m_mode == M_SETTLE) || (m_mode == M_UP)));
      check("m_sync_error",      32'(sync_error),          32'(m_err));
      check("m_debug_status",    debug_status,             exp_dbg);
   end

   // ---------------- driver tasks ----------------
   task automatic step();
      @(posedge clk_wr);
      @(negedge clk_wr);
   endtask

   task automatic wait_rx_up(input int budget, input string name);
      int n = 0;
      while (rx_online_delay !== 1'b1 && n < budget) begin
         step();
         n++;
      end
      check(name, 32'(rx_online_delay), 32'd1);
   endtask

   task automatic pulse_reset();
      #2 rst_wr_n = 1'b0;
      #1 check("async_rst_debug", debug_status, 32'h0);
      check("async_rst_outs", {26'd0, tx_online_delay, rx_online_delay, tx_auto_stb_userbit,
                               tx_auto_mrk_userbit, sync_locked}, 32'h0);
      check("async_rst_err", 32'(sync_error), 32'd0);
      #1 rst_wr_n = 1'b1;
      @(negedge clk_wr);
   endtask

   // ---------------- stimulus ----------------
   logic [7:0] pat;

   initial begin
      repeat (3) step();
      check("reset_debug", debug_status, 32'h0);
      check("reset_outs", {26'd0, tx_online_delay, rx_online_delay, tx_auto_stb_userbit,
                           tx_auto_mrk_userbit, sync_locked}, 32'h0);
      rst_wr_n = 1'b1;
      step();
      check("idle_debug", debug_status, 32'h0);

      // TX delay 3: tx_online high at edge 0, output high after edge 4.
      delay_y_value = 16'd3;
      tx_online = 1'b1;
      step();
      check("tx_dly_state", 32'(debug_status[28:27]), 32'(TX_DLY));
      delay_y_value = 16'd9;   // mid-count change must be ignored
      repeat (3) step();
      check("tx_edge3_low", 32'(tx_online_delay), 32'd0);
      step();
      check("tx_edge4_high", 32'(tx_online_delay), 32'd1);
      check("tx_edge4_stb", 32'(tx_auto_stb_userbit), 32'd1);
      check("tx_edge4_mrk", 32'(tx_auto_mrk_userbit), 32'd3);

      // Lock with continuous strobe, delay_x=2.
      delay_x_value = 16'd2;
      rx_online = 1'b1;
      rx_stb_userbit = 1'b1;
      step();
      check("rx_hunt_entry", 32'(debug_status[31:29]), 32'(RX_HUNT));
      repeat (3) step();
      check("lock_3rd_low", 32'(sync_locked), 32'd0);
      check("lock_3rd_hunt", 32'(debug_status[25:22]), 32'd3);
      step();
      check("lock_4th_high", 32'(sync_locked), 32'd1);
      check("lock_4th_dly", 32'(debug_status[31:29]), 32'(RX_DLY));
      delay_x_value = 16'd7;
      repeat (2) step();
      check("rxon_edge2_low", 32'(rx_online_delay), 32'd0);
      step();
      check("rxon_edge3_high", 32'(rx_online_delay), 32'd1);

      // Strobe loss with delay_z=5.
      delay_z_value = 16'd5;
      rx_stb_userbit = 1'b0;
      step();
      check("loss_rxon_low", 32'(rx_online_delay), 32'd0);
      check("loss_err", 32'(sync_error), 32'd1);
      check("loss_errcnt", 32'(debug_status[15:8]), 32'd1);
      check("loss_backoff", 32'(debug_status[31:29]), 32'(RX_BACKOFF));
      rx_stb_userbit = 1'b1;
      delay_z_value = 16'd9;
      repeat (5) step();
      check("backoff_hold", 32'(debug_status[31:29]), 32'(RX_BACKOFF));
      step();
      check("backoff_rehunt", 32'(debug_status[31:29]), 32'(RX_HUNT));

      // Broken hunt 1,1,1,0,1,1,1,1.
      delay_x_value = 16'd2;
      pat = 8'b1111_0111;
      for (int i = 0; i < 8; i++) begin
         rx_stb_userbit = pat[i];
         step();
         if (i == 2) check("hunt_three", 32'(debug_status[25:22]), 32'd3);
         if (i == 3) check("hunt_cleared", 32'(debug_status[25:22]), 32'd0);
         if (i == 6) check("hunt_no_lock", 32'(debug_status[31:29]), 32'(RX_HUNT));
         if (i == 7) check("hunt_lock", 32'(sync_locked), 32'd1);
      end
      check("err_still_set", 32'(sync_error), 32'd1);

      // TX drop during RX_DLY takes both FSMs off on the next edge.
      tx_online = 1'b0;
      step();
      check("drop_states", 32'(debug_status[31:27]), 32'd0);
      check("drop_outs", {28'd0, tx_online_delay, rx_online_delay, tx_auto_stb_userbit,
                          sync_locked}, 32'h0);

      // Bring link up again, then reset asynchronously in RX_ON.
      delay_y_value = 16'd1;
      tx_online = 1'b1;
      wait_rx_up(100, "relink_up");
      pulse_reset();
      step();
      check("resume_tx_dly", 32'(debug_status[28:27]), 32'(TX_DLY));
      check("resume_rx_off", 32'(debug_status[31:29]), 32'(RX_OFF));

      // Long delay: 16'hFFFF must not underflow into an early TX_ON.
      tx_online = 1'b0;
      step();
      delay_y_value = 16'hFFFF;
      tx_online = 1'b1;
      repeat (200) step();
      check("ffff_still_dly", 32'(debug_status[28:27]), 32'(TX_DLY));

      // Randomized traffic, checked every cycle by the model.
      for (int c = 0; c < 3000; c++) begin
         tx_online      = ($urandom_range(0, 99) < 99);
         rx_online      = ($urandom_range(0, 99) < 99);
         rx_stb_userbit = ($urandom_range(0, 99) < 94);
         delay_x_value  = 16'($urandom_range(0, 6));
         delay_y_value  = 16'($urandom_range(0, 6));
         delay_z_value  = 16'($urandom_range(0, 6));
         if ($urandom_range(0, 599) == 0) pulse_reset();
         else step();
      end

      // Error counter saturation.
      pulse_reset();
      tx_online = 1'b1;
      rx_online = 1'b1;
      rx_stb_userbit = 1'b1;
      delay_x_value = 16'd0;
      delay_y_value = 16'd0;
      delay_z_value = 16'd0;
      for (int k = 0; k < 260; k++) begin
         wait_rx_up(60, "sat_lock");
         rx_stb_userbit = 1'b0;
         step();
         rx_stb_userbit = 1'b1;
      end
      check("errcnt_saturated", 32'(debug_status[15:8]), 32'hFF);
      check("err_sticky", 32'(sync_error), 32'd1);

      step();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/lpif_slave_link_sync.md
LPIF_SLAVE_LINK_SYNC -- requirements
Module: lpif_slave_link_sync

Interface
REQ-001 SHALL have parameter STB_LOCK, default 4: consecutive received strobe cycles required for lock (range 1..15).
REQ-002 SHALL have parameter MARKER_WIDTH, default 2: width of the TX marker userbit field.
REQ-003 SHALL use a single clock and an asynchronous active-low reset; ports are listed below.
- clk_wr  in  1  single clock; all logic sampled on its rising edge.
- rst_wr_n  in  1  asynchronous active-low reset.
- tx_online  in  1  local TX PHY online.
- rx_online  in  1  local RX PHY online.
- rx_stb_userbit  in  1  strobe bit extracted from each received slave-end word.
- delay_x_value  in  16  RX post-lock delay, in cycles.
- delay_y_value  in  16  TX online delay, in cycles.
- delay_z_value  in  16  RX re-hunt backoff after a strobe loss, in cycles.
- tx_online_delay  out  1  delayed TX online; drives the concat tx_online input.
- rx_online_delay  out  1  RX datapath qualified.
- tx_auto_stb_userbit  out  1  generated persistent strobe.
- tx_auto_mrk_userbit  out  MARKER_WIDTH  generated persistent marker.
- sync_locked  out  1  high while RX is in state RX_DLY or RX_ON.
- sync_error  out  1  sticky strobe-loss flag.
- debug_status  out  32  state and counter snapshot.

Function
REQ-004 SHALL implement TX FSM states TX_OFF, TX_DLY and TX_ON.
- TX_OFF -> TX_DLY when tx_online=1; tx_cnt loads delay_y_value.
- In TX_DLY, when tx_cnt==0 -> TX_ON; otherwise tx_cnt decrements.
- tx_online=0 in any state -> TX_OFF on the next edge.
REQ-005 SHALL drive tx_online_delay=1 iff TX state is TX_ON, as a registered output. If tx_online is first sampled high at edge k, tx_online_delay SHALL be high after edge k+delay_y_value+1.
REQ-006 SHALL drive tx_auto_stb_userbit=tx_online_delay and tx_auto_mrk_userbit={MARKER_WIDTH{tx_online_delay}} (persistent strobe and marker), both registered.
REQ-007 SHALL implement RX FSM states RX_OFF, RX_HUNT, RX_DLY, RX_ON and RX_BACKOFF.
- RX_OFF -> RX_HUNT when rx_online=1 and tx_online_delay=1; hunt_cnt clears.
- RX_HUNT: hunt_cnt increments when rx_stb_userbit=1 and clears when it is 0.
- RX_HUNT -> RX_DLY on the edge where rx_stb_userbit=1 and hunt_cnt==STB_LOCK-1; rx_cnt loads delay_x_value.
- RX_DLY: when rx_cnt==0 -> RX_ON; otherwise rx_cnt decrements. rx_stb_userbit=0 in RX_DLY -> RX_HUNT, with no error recorded.
- RX_ON: rx_stb_userbit=0 -> RX_BACKOFF; rx_cnt loads delay_z_value; sync_error sets; err_cnt increments.
- RX_BACKOFF: when rx_cnt==0 -> RX_HUNT; otherwise rx_cnt decrements. rx_stb_userbit is ignored in this state.
REQ-008 SHALL force RX to RX_OFF on the next edge from any state when rx_online=0 or tx_online_delay=0. This rule has priority over all other RX transitions.
REQ-009 SHALL drive rx_online_delay=1 iff RX state is RX_ON, as a registered output.
REQ-010 SHALL keep sync_error set until reset.
REQ-011 SHALL keep err_cnt as an 8-bit counter that saturates at 8'hFF with no wrap.
REQ-012 SHALL hold hunt_cnt as 4 bits that never exceeds STB_LOCK-1.
REQ-013 SHALL hold delay counters as 16 bits with no underflow. A delay_*_value of 16'hFFFF SHALL give 65536 cycles in the delay state.
REQ-014 SHALL sample delay_*_value only when the corresponding counter loads. Changes during a count SHALL be ignored.
REQ-015 SHALL assemble debug_status as follows:
- [31:29] RX state encoding.
- [28:27] TX state encoding.
- [26] sync_error.
- [25:22] hunt_cnt.
- [21] tx_online_delay.
- [20] rx_online_delay.
- [15:8] err_cnt.
- all other bits 0.

Reset
REQ-016 SHALL, while rst_wr_n=0, asynchronously force:
- TX to TX_OFF and RX to RX_OFF;
- all counters to 0;
- all outputs to 0, including debug_status=32'h0.
REQ-017 SHALL, on reset deassertion mid-operation, resume from the OFF states only; no partial state SHALL persist.

Structure
REQ-018 SHALL place the TX and RX state enums (2-bit and 3-bit encodings) and the default STB_LOCK constant in the shared package lpif_link_sync_pkg.
REQ-019 SHALL instantiate sub-module lpif_sync_dly_cnt (16-bit load/decrement/zero-detect) twice: once for tx_cnt and once for rx_cnt.

Verification
REQ-020 TX delay: delay_y=3, tx_online rises at edge 0 -> tx_online_delay, tx_auto_stb_userbit and tx_auto_mrk_userbit=2'b11 are high after edge 4.
REQ-021 Lock: STB_LOCK=4, delay_x=2, rx_stb_userbit=1 continuously -> sync_locked after the 4th strobe edge; rx_online_delay 3 edges later.
REQ-022 Broken hunt: strobe pattern 1,1,1,0,1,1,1,1 -> hunt_cnt clears at the 0; lock occurs only after the final four 1s.
REQ-023 Strobe loss: in RX_ON, one 0 with delay_z=5 ->
- rx_online_delay drops next edge;
- sync_error=1 and err_cnt=1;
- RX_HUNT re-entered 6 edges later.
REQ-024 Drop priority: tx_online=0 during RX_DLY -> TX_OFF and RX_OFF on the next edge; all online outputs are 0.
REQ-025 Reset: rst_wr_n pulsed low in RX_ON -> all outputs 0 immediately, with no clock edge required.
